// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter in front of the single RegisterFile write port.
// Accepted writes pass through an in-order queue that drains one entry per cycle.
module regfile_wr_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [AW-1:0]            in0_rw,
  input  logic [DW-1:0]            in0_data,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  input  logic [AW-1:0]            in1_rw,
  input  logic [DW-1:0]            in1_data,
  output logic [AW-1:0]            RW,
  output logic [DW-1:0]            BusW,
  output logic                     RegWr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] rw_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr1_ptr;
  logic          rr_pref_q, rr_pref_d;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] busw_q;
  logic          regwr_q;

  logic [CW-1:0] free;
  logic          free_many, free_one;
  logic          acc0, acc1, enq0, enq1, pop;

  // Free space is judged before this cycle's pop, so a drain never makes room early.
  assign free      = CW'(DEPTH) - count_q;
  assign free_many = free >= CW'(2);
  assign free_one  = free == CW'(1);

  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (Rst) begin
      in0_ready = free_many | (free_one & in0_valid & (~in1_valid | ~rr_pref_q));
      in1_ready = free_many | (free_one & in1_valid & (~in0_valid |  rr_pref_q));
    end
  end

  assign acc0 = in0_valid & in0_ready;
  assign acc1 = in1_valid & in1_ready;
  assign enq0 = acc0 & (in0_rw != '0);
  assign enq1 = acc1 & (in1_rw != '0);
  assign pop  = count_q != '0;

  assign wr1_ptr   = wr_ptr_q + PW'(enq0);
  assign wr_ptr_d  = wr1_ptr + PW'(enq1);
  assign rd_ptr_d  = rd_ptr_q + PW'(pop);
  assign count_d   = count_q + CW'(enq0) + CW'(enq1) - CW'(pop);
  assign rr_pref_d = (free_one & in0_valid & in1_valid) ? ~rr_pref_q : rr_pref_q;

  // Queue storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge Clk) begin
    if (enq0) begin
      rw_mem[wr_ptr_q]   <= in0_rw;
      data_mem[wr_ptr_q] <= in0_data;
    end
    if (enq1) begin
      rw_mem[wr1_ptr]   <= in1_rw;
      data_mem[wr1_ptr] <= in1_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_pref_q <= 1'b0;
      rw_q      <= '0;
      busw_q    <= '0;
      regwr_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rr_pref_q <= rr_pref_d;
      regwr_q   <= pop;
      if (pop) begin
        rw_q   <= rw_mem[rd_ptr_q];
        busw_q <= data_mem[rd_ptr_q];
      end
    end
  end

  assign RW    = rw_q;
  assign BusW  = busw_q;
  assign RegWr = regwr_q;
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed steps plus random traffic against a queue-based model.
module tb_regfile_wr_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          in0_valid = 1'b0, in1_valid = 1'b0;
  logic          in0_ready, in1_ready;
  logic [AW-1:0] in0_rw = '0, in1_rw = '0;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic [AW-1:0] RW;
  logic [DW-1:0] BusW;
  logic          RegWr;
  logic [2:0]    count;
  logic          full, empty;

  regfile_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_rw(in0_rw), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_rw(in1_rw), .in1_data(in1_data),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .count(count), .full(full), .empty(empty)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] rw;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_regwr = 1'b0;
  logic [AW-1:0] m_rw    = '0;
  logic [DW-1:0] m_busw  = '0;
  bit            m_pref  = 1'b0;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("RegWr", 64'(RegWr), 64'(m_regwr));
    chk("RW",    64'(RW),    64'(m_rw));
    chk("BusW",  64'(BusW),  64'(m_busw));
    chk("count", 64'(count), 64'(mq.size()));
    chk("full",  64'(full),  64'(mq.size() == DEPTH));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
  endtask

  task automatic model_reset();
    mq.delete();
    m_regwr = 1'b0;
    m_rw    = '0;
    m_busw  = '0;
    m_pref  = 1'b0;
  endtask

  // One clock of traffic: drive after the falling edge, check, then advance the model
  // to what the next rising edge must produce.
  task automatic step(input bit v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    int  free;
    bit  e0, e1, known;
    ent_t e;
    @(negedge Clk);
    in0_valid = v0; in0_rw = r0; in0_data = d0;
    in1_valid = v1; in1_rw = r1; in1_data = d1;
    #1;
    free  = DEPTH - mq.size();
    known = 1'b1;
    e0 = 1'b0; e1 = 1'b0;
    if (free >= 2) begin
      e0 = 1'b1; e1 = 1'b1;
    end else if (free == 1) begin
      if (v0 && v1) begin
        e0 = !m_pref; e1 = m_pref;
      end else if (v0) e0 = 1'b1;
      else if (v1) e1 = 1'b1;
      else known = 1'b0;
    end
    if (known) begin
      chk("in0_ready", 64'(in0_ready), 64'(e0));
      chk("in1_ready", 64'(in1_ready), 64'(e1));
    end
    chk_outputs();
    if (free == 1 && v0 && v1) m_pref = !m_pref;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_regwr = 1'b1; m_rw = e.rw; m_busw = e.d;
    end else begin
      m_regwr = 1'b0;
    end
    if (v0 && e0 && r0 != 0) mq.push_back('{r0, d0});
    if (v1 && e1 && r1 != 0) mq.push_back('{r1, d1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] dat;
    logic [AW-1:0] ra, rb;
    bit va, vb;

    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      chk("rst_in0_ready", 64'(in0_ready), 64'd0);
      chk("rst_in1_ready", 64'(in1_ready), 64'd0);
      chk_outputs();
    end
    @(negedge Clk);
    Rst = 1'b1;

    // Reset release, then a single in0 write.
    idle(1);
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    idle(3);

    // Same-destination pair in one cycle: 0x11 then 0x22.
    step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    idle(4);

    // Saturating traffic from both sides exercises the free==1 round robin.
    dat = 32'h100;
    for (int i = 0; i < 12; i++) begin
      step(1, 5'(i % 31 + 1), dat, 1, 5'((i + 7) % 31 + 1), dat + 1);
      dat = dat + 2;
    end
    idle(5);

    // Writes to register 0 are acknowledged and dropped.
    step(1, 5'd0, 32'hFFFFFFFF, 0, '0, '0);
    step(0, '0, '0, 1, 5'd0, 32'h12345678);
    idle(3);

    // Fill to three entries then assert reset mid-cycle.
    step(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
    step(1, 5'd3, 32'hC3, 1, 5'd4, 32'hD4);
    @(negedge Clk);
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    chk("pre_rst_count", 64'(count), 64'd3);
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_in0_ready", 64'(in0_ready), 64'd0);
    chk("midrst_in1_ready", 64'(in1_ready), 64'd0);
    chk_outputs();
    @(negedge Clk); #1;
    chk_outputs();
    @(negedge Clk);
    Rst = 1'b1;
    idle(5);

    // Random traffic, including rw==0 writes.
    for (int i = 0; i < 400; i++) begin
      va = $urandom_range(0, 3) != 0;
      vb = $urandom_range(0, 3) != 0;
      ra = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rb = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(va, ra, $urandom, vb, rb, $urandom);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
